// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared types, constants and golden error function for the sensor sweep
package sensor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } sweep_state_t;

   localparam int NUM_VECTORS = 16;

   // Reference behaviour of the 4-bit sensor error detector.
   function automatic logic golden_error(input logic [3:0] v);
      return v[0] | (v[1] & (v[2] | v[3]));
   endfunction

endpackage

// File: rtl/sensor_dwell_cnt.sv
// rtl/sensor_dwell_cnt.sv - rollover counter timing how long each vector is held
module sensor_dwell_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] max_count,
   output logic             wrap
);

   logic [WIDTH-1:0] count;

   // Flag is asserted on the last cycle of the window so the caller acts on that edge.
   assign wrap = enable && (count == max_count);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (wrap) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sensor_sweep.sv
// rtl/sensor_sweep.sv - sweeps all 16 sensor vectors into the detector and records its error responses
module sensor_sweep
   import sensor_pkg::*;
#(
   parameter int DWELL = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic        error_in,
   output logic [3:0]  sensors,
   output logic        busy,
   output logic        done,
   output logic [15:0] err_map,
   output logic [4:0]  err_count,
   output logic [15:0] mismatch_map
);

   localparam logic [7:0] DWELL_MAX  = 8'(DWELL - 1);
   localparam logic [3:0] LAST_INDEX = 4'(NUM_VECTORS - 1);

   sweep_state_t state;
   logic [3:0]   idx;
   logic         dwell_wrap;

   // Counter is held at zero outside DRIVE, so every sweep starts a fresh window.
   sensor_dwell_cnt #(
      .WIDTH(8)
   ) u_dwell_cnt (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (state != DRIVE),
      .enable   (state == DRIVE),
      .max_count(DWELL_MAX),
      .wrap     (dwell_wrap)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         idx          <= '0;
         sensors      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_map      <= '0;
         err_count    <= '0;
         mismatch_map <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  state        <= DRIVE;
                  busy         <= 1'b1;
                  idx          <= '0;
                  sensors      <= '0;
                  err_map      <= '0;
                  err_count    <= '0;
                  mismatch_map <= '0;
               end
            end
            DRIVE: begin
               if (dwell_wrap) begin
                  err_map[idx]      <= error_in;
                  mismatch_map[idx] <= error_in ^ golden_error(idx);
                  err_count         <= err_count + {4'b0000, error_in};
                  if (idx == LAST_INDEX) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx     <= idx + 4'd1;
                     sensors <= idx + 4'd1;
                  end
               end
            end
            DONE: begin
               // start is deliberately not looked at here; a restart needs one IDLE cycle.
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_sweep.sv
// tb/tb_sensor_sweep.sv - directed self-checking bench for sensor_sweep at DWELL=2 and DWELL=1
module tb_sensor_sweep;

   logic clk = 1'b0;
   logic rst1, rst2;
   logic go, sel;
   logic [1:0] mode2;

   logic start1, start2, err1, err2;
   logic [3:0] sens1, sens2;
   logic busy1, busy2, done1, done2;
   logic [15:0] map1, map2, mis1, mis2;
   logic [4:0] cnt1, cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic det(input logic [3:0] v);
      return v[0] | (v[1] & (v[2] | v[3]));
   endfunction

   assign start1 = go & sel;
   assign start2 = go & ~sel;
   // mode2: 0 = healthy detector, 1 = stuck at 0, 2 = stuck at 1
   assign err2 = (mode2 == 2'd0) ? det(sens2) : (mode2 == 2'd1) ? 1'b0 : 1'b1;
   assign err1 = det(sens1) & (sens1 != 4'd6);

   sensor_sweep #(.DWELL(2)) u_dut2 (
      .clk(clk), .n_rst(rst2), .start(start2), .error_in(err2),
      .sensors(sens2), .busy(busy2), .done(done2),
      .err_map(map2), .err_count(cnt2), .mismatch_map(mis2)
   );

   sensor_sweep #(.DWELL(1)) u_dut1 (
      .clk(clk), .n_rst(rst1), .start(start1), .error_in(err1),
      .sensors(sens1), .busy(busy1), .done(done1),
      .err_map(map1), .err_count(cnt1), .mismatch_map(mis1)
   );

   logic [3:0]  sens_m;
   logic        busy_m, done_m;
   logic [15:0] map_m, mis_m;
   logic [4:0]  cnt_m;
   assign sens_m = sel ? sens1 : sens2;
   assign busy_m = sel ? busy1 : busy2;
   assign done_m = sel ? done1 : done2;
   assign map_m  = sel ? map1  : map2;
   assign mis_m  = sel ? mis1  : mis2;
   assign cnt_m  = sel ? cnt1  : cnt2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle dcyc+1 when stop_early is set.
   task automatic sweep(input int dwell, input int pulse_at, input bit pulse_done, input bit stop_early,
                        output int bcnt, output int dcyc, output int dcnt, output int seq_err,
                        output logic [15:0] first_map, output logic [15:0] first_mis,
                        output logic [4:0] first_cnt);
      int cyc;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      cyc = 1;
      bcnt = 0; dcyc = 0; dcnt = 0; seq_err = 0;
      first_map = map_m; first_mis = mis_m; first_cnt = cnt_m;
      while (cyc < 16 * dwell + 12 && !(stop_early && dcyc != 0 && cyc == dcyc + 1)) begin
         if (busy_m) begin
            bcnt++;
            if (sens_m !== 4'((cyc - 1) / dwell)) seq_err++;
         end
         if (done_m) begin
            dcnt++;
            if (dcyc == 0) dcyc = cyc;
         end
         go = (cyc == pulse_at) || (pulse_done && done_m);
         @(negedge clk);
         cyc++;
      end
      go = 1'b0;
   endtask

   int bc, dc, dn, se;
   logic [15:0] fm, fx;
   logic [4:0] fc;

   initial begin
      rst1 = 1'b0; rst2 = 1'b0; go = 1'b0; sel = 1'b0; mode2 = 2'd0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_sensors", 32'(sens2), 32'h0);
      chk("rst_busy", 32'(busy2), 32'h0);
      chk("rst_done", 32'(done2), 32'h0);
      chk("rst_err_map", 32'(map2), 32'h0);
      chk("rst_err_count", 32'(cnt2), 32'h0);
      chk("rst_mismatch", 32'(mis2), 32'h0);
      rst1 = 1'b1; rst2 = 1'b1;
      @(negedge clk);

      // Reset in the middle of a DWELL=2 sweep.
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_busy", 32'(busy2), 32'h1);
      chk("mid_sensors", 32'(sens2), 32'h4);
      chk("mid_err_map", 32'(map2), 32'hA);
      rst2 = 1'b0;
      #1;
      chk("arst_sensors", 32'(sens2), 32'h0);
      chk("arst_busy", 32'(busy2), 32'h0);
      chk("arst_done", 32'(done2), 32'h0);
      chk("arst_err_map", 32'(map2), 32'h0);
      chk("arst_err_count", 32'(cnt2), 32'h0);
      chk("arst_mismatch", 32'(mis2), 32'h0);
      @(negedge clk);
      rst2 = 1'b1;
      @(negedge clk);

      // Healthy detector, DWELL=2.
      sweep(2, 0, 1'b0, 1'b0, bc, dc, dn, se, fm, fx, fc);
      chk("gold_busy_cycles", 32'(bc), 32'd32);
      chk("gold_done_cycle", 32'(dc), 32'd33);
      chk("gold_done_pulses", 32'(dn), 32'd1);
      chk("gold_sequence", 32'(se), 32'd0);
      chk("gold_err_map", 32'(map2), 32'hEEEA);
      chk("gold_err_count", 32'(cnt2), 32'd11);
      chk("gold_mismatch", 32'(mis2), 32'h0000);

      // Stuck-at-0 detector with stray start pulses while busy and in DONE.
      mode2 = 2'd1;
      sweep(2, 7, 1'b1, 1'b0, bc, dc, dn, se, fm, fx, fc);
      chk("zero_busy_cycles", 32'(bc), 32'd32);
      chk("zero_done_cycle", 32'(dc), 32'd33);
      chk("zero_done_pulses", 32'(dn), 32'd1);
      chk("zero_sequence", 32'(se), 32'd0);
      chk("zero_err_map", 32'(map2), 32'h0000);
      chk("zero_err_count", 32'(cnt2), 32'd0);
      chk("zero_mismatch", 32'(mis2), 32'hEEEA);

      // DWELL=1 detector faulty only at vector 6.
      sel = 1'b1;
      sweep(1, 0, 1'b0, 1'b0, bc, dc, dn, se, fm, fx, fc);
      chk("d1_busy_cycles", 32'(bc), 32'd16);
      chk("d1_done_cycle", 32'(dc), 32'd17);
      chk("d1_sequence", 32'(se), 32'd0);
      chk("d1_err_map", 32'(map1), 32'hEEAA);
      chk("d1_err_count", 32'(cnt1), 32'd10);
      chk("d1_mismatch", 32'(mis1), 32'h0040);

      // Back-to-back sweeps on DWELL=2: healthy, then stuck-at-1.
      sel = 1'b0;
      mode2 = 2'd0;
      sweep(2, 0, 1'b0, 1'b1, bc, dc, dn, se, fm, fx, fc);
      chk("b2b_a_clear_mismatch", 32'(fx), 32'h0);
      chk("b2b_a_done_cycle", 32'(dc), 32'd33);
      chk("b2b_a_err_map", 32'(map2), 32'hEEEA);
      mode2 = 2'd2;
      sweep(2, 0, 1'b0, 1'b0, bc, dc, dn, se, fm, fx, fc);
      chk("b2b_b_clear_map", 32'(fm), 32'h0);
      chk("b2b_b_clear_count", 32'(fc), 32'h0);
      chk("b2b_b_busy_cycles", 32'(bc), 32'd32);
      chk("b2b_b_done_cycle", 32'(dc), 32'd33);
      chk("b2b_b_sequence", 32'(se), 32'd0);
      chk("b2b_b_err_map", 32'(map2), 32'hFFFF);
      chk("b2b_b_err_count", 32'(cnt2), 32'd16);
      chk("b2b_b_mismatch", 32'(mis2), 32'h1115);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
